vga_sync: RTL and testbench
===========================

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter H_VISIBLE, default 800: active pixels per line.
REQ-002 Parameter H_FP, default 56: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 120: hsync pulse width, in pixels.
REQ-004 Parameter H_BP, default 64: horizontal back porch; H_TOTAL = 1040.
REQ-005 Parameter V_VISIBLE, default 600: active lines per frame.
REQ-006 Parameter V_FP, default 37: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 6: vsync pulse width, in lines.
REQ-008 Parameter V_BP, default 23: vertical back porch; V_TOTAL = 666.
REQ-009 Parameter H_POL, default 1: hsync active level.
REQ-010 Parameter V_POL, default 1: vsync active level.
REQ-011 clk  input  1: pixel clock, 50 MHz (the divided dclk); all logic on its rising edge.
REQ-012 rst_n  input  1: reset, asynchronous, active-low.
REQ-013 en  input  1: pixel advance enable.
REQ-014 hsync  output  1: horizontal sync, registered.
REQ-015 vsync  output  1: vertical sync, registered.
REQ-016 video_on  output  1: high inside the active region.
REQ-017 pixel_x  output  11: horizontal position, 0..H_TOTAL-1.
REQ-018 pixel_y  output  10: vertical position, 0..V_TOTAL-1.
REQ-019 line_start  output  1: one-cycle pulse at the start of each line.
REQ-020 frame_start  output  1: one-cycle pulse at the start of each frame.

Function
REQ-021 Internal counters h_cnt (11 bit) and v_cnt (10 bit) SHALL advance only on rising clk edges with en=1.
REQ-022 h_cnt wrap: at H_TOTAL-1 it SHALL go to 0 and v_cnt SHALL increment; otherwise h_cnt increments by 1.
REQ-023 v_cnt wrap: at V_TOTAL-1, coincident with h_cnt at H_TOTAL-1, both counters SHALL go to 0 on the same edge.
REQ-024 Horizontal phase FSM ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE SHALL be derived from h_cnt.
- Boundaries: FRONT at h_cnt=H_VISIBLE; SYNC at H_VISIBLE+H_FP; BACK at H_VISIBLE+H_FP+H_SYNC; ACTIVE at 0.
- The vertical axis SHALL use the same four phases on v_cnt.
REQ-025 All outputs SHALL be registered and SHALL reflect the counter values of the previous enabled cycle (latency 1).
- pixel_x and pixel_y SHALL always equal the sampled h_cnt and v_cnt.
REQ-026 hsync SHALL equal H_POL while sampled h_cnt is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] (default 856..975), else ~H_POL.
REQ-027 vsync SHALL equal V_POL while sampled v_cnt is in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] (default 637..642), else ~V_POL; it is line-aligned, changing with the pixel_x=0 update.
REQ-028 video_on SHALL be 1 iff sampled h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
REQ-029 line_start SHALL be 1 for exactly one clk when outputs update to pixel_x=0; frame_start likewise when outputs update to pixel_x=0 and pixel_y=0.
REQ-030 While en=0: counters and level outputs SHALL hold; line_start and frame_start SHALL be 0.
REQ-031 Counters SHALL never exceed H_TOTAL-1 or V_TOTAL-1.

Reset
REQ-032 While rst_n=0 the outputs SHALL be, asynchronously:
- h_cnt = v_cnt = 0, pixel_x = 0, pixel_y = 0;
- hsync = ~H_POL, vsync = ~V_POL;
- video_on = 0, line_start = 0, frame_start = 0.
REQ-033 After deassertion, the first enabled edge SHALL present pixel_x=0, pixel_y=0, video_on=1, line_start=1, frame_start=1.
REQ-034 Reset asserted mid-frame SHALL abort the frame; counting SHALL restart from 0,0 with no partial sync pulse held.

Verification
REQ-035 Reset release, en=1 -> first edge: frame_start=1, line_start=1, video_on=1; hsync=0, vsync=0.
REQ-036 Line 0 scan -> video_on falls at pixel_x=800; hsync high for pixel_x 856..975 (120 cycles); line_start again 1040 cycles after the first.
REQ-037 Full frame -> vsync high for pixel_y 637..642 (6×1040 cycles); frame_start pulses exactly 692640 enabled cycles apart.
REQ-038 Wrap check -> h=1039, v=665 then next edge gives 0,0 with frame_start=1; h=1039, v=10 gives h=0, v=11 with line_start=1 only.
REQ-039 Drop en for 7 cycles at pixel_x=500 -> all outputs frozen, no pulses; resume continues at 501.
REQ-040 rst_n low at pixel_x=900, pixel_y=640 -> hsync=0, vsync=0, counters 0 immediately (no clock edge needed); restart per REQ-033.

Source files
------------

// File: rtl/vga_sync_if.sv
// Video timing bundle between the sync generator and its consumer.
// The consumer drives the pixel-advance enable and receives position, syncs and pulses.
interface vga_sync_if;
  logic        en;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic        line_start;
  logic        frame_start;

  modport master (
    input  en,
    output hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    output en,
    input  hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
  );
endinterface

// File: rtl/vga_sync.sv
// VGA timing generator: pixel/line counters, per-axis phase FSMs and registered sync outputs.
// Outputs are registered from the counter values of the previous enabled cycle.
//
// state     | meaning
// PH_ACTIVE | visible region (counter below the visible size)
// PH_FRONT  | front porch
// PH_SYNC   | sync pulse asserted
// PH_BACK   | back porch
module vga_sync #(
  parameter int H_VISIBLE = 800,
  parameter int H_FP      = 56,
  parameter int H_SYNC    = 120,
  parameter int H_BP      = 64,
  parameter int V_VISIBLE = 600,
  parameter int V_FP      = 37,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 23,
  parameter int H_POL     = 1,
  parameter int V_POL     = 1
) (
  input logic       clk,
  input logic       rst_n,
  vga_sync_if.master vif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_B_FRONT = 11'(H_VISIBLE);
  localparam logic [10:0] H_B_SYNC  = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_B_BACK  = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_B_FRONT = 10'(V_VISIBLE);
  localparam logic [9:0]  V_B_SYNC  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  V_B_BACK  = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic        H_ACT     = (H_POL != 0);
  localparam logic        V_ACT     = (V_POL != 0);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_e;

  // Later boundaries win so a zero-width porch collapses onto the following phase.
  function automatic phase_e h_phase_at(logic [10:0] cnt, phase_e cur);
    phase_e nxt;
    nxt = cur;
    if (cnt == H_B_BACK)       nxt = PH_BACK;
    else if (cnt == H_B_SYNC)  nxt = PH_SYNC;
    else if (cnt == H_B_FRONT) nxt = PH_FRONT;
    else if (cnt == 11'd0)     nxt = PH_ACTIVE;
    return nxt;
  endfunction

  function automatic phase_e v_phase_at(logic [9:0] cnt, phase_e cur);
    phase_e nxt;
    nxt = cur;
    if (cnt == V_B_BACK)       nxt = PH_BACK;
    else if (cnt == V_B_SYNC)  nxt = PH_SYNC;
    else if (cnt == V_B_FRONT) nxt = PH_FRONT;
    else if (cnt == 10'd0)     nxt = PH_ACTIVE;
    return nxt;
  endfunction

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  phase_e      h_ph_q, h_ph_d;
  phase_e      v_ph_q, v_ph_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_on_q, video_on_d;
  logic [10:0] pixel_x_q, pixel_x_d;
  logic [9:0]  pixel_y_q, pixel_y_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    h_ph_d        = h_ph_q;
    v_ph_d        = v_ph_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (vif.en) begin
      // >= keeps the counters inside range even if they were ever disturbed
      if (h_cnt_q >= H_LAST) begin
        h_cnt_d = 11'd0;
        v_cnt_d = (v_cnt_q >= V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
      h_ph_d        = h_phase_at(h_cnt_d, h_ph_q);
      v_ph_d        = v_phase_at(v_cnt_d, v_ph_q);
      pixel_x_d     = h_cnt_q;
      pixel_y_d     = v_cnt_q;
      hsync_d       = (h_ph_q == PH_SYNC) ? H_ACT : ~H_ACT;
      vsync_d       = (v_ph_q == PH_SYNC) ? V_ACT : ~V_ACT;
      video_on_d    = (h_ph_q == PH_ACTIVE) && (v_ph_q == PH_ACTIVE);
      line_start_d  = (h_cnt_q == 11'd0);
      frame_start_d = (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= 11'd0;
      v_cnt_q       <= 10'd0;
      h_ph_q        <= PH_ACTIVE;
      v_ph_q        <= PH_ACTIVE;
      hsync_q       <= ~H_ACT;
      vsync_q       <= ~V_ACT;
      video_on_q    <= 1'b0;
      pixel_x_q     <= 11'd0;
      pixel_y_q     <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_ph_q        <= h_ph_d;
      v_ph_q        <= v_ph_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.video_on    = video_on_q;
  assign vif.pixel_x     = pixel_x_q;
  assign vif.pixel_y     = pixel_y_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default-timing instance for line-level behaviour and a tiny,
// inverted-polarity instance for frame-level behaviour, both checked against a range-based model.
module tb_vga_sync;

  localparam int A_HT = 1040;
  localparam int A_VT = 666;
  localparam int B_HV = 10, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VV = 6,  B_VF = 2, B_VS = 2, B_VB = 3;
  localparam int B_HT = B_HV + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VV + B_VF + B_VS + B_VB;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        von;
    logic        ls;
    logic        fs;
    logic [10:0] x;
    logic [9:0]  y;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  vga_sync_if ifa ();
  vga_sync_if ifb ();

  vga_sync ua (.clk(clk), .rst_n(rst_a_n), .vif(ifa.master));

  vga_sync #(
    .H_VISIBLE(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_VISIBLE(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .H_POL(0), .V_POL(0)
  ) ub (.clk(clk), .rst_n(rst_b_n), .vif(ifb.master));

  always #5 clk = ~clk;

  int   ah = 0, av = 0, bh = 0, bv = 0;
  obs_t ea, eb;
  int   en_cnt_b = 0;
  int   last_fs_b = -1;
  int   vs_cnt_b = 0;
  int   frames_b = 0;

  function automatic obs_t predict(int h, int v, int hv, int hf, int hsw,
                                   int vv, int vf, int vsw, bit hp, bit vp);
    obs_t e;
    e.x   = 11'(h);
    e.y   = 10'(v);
    e.hs  = (h >= hv + hf && h < hv + hf + hsw) ? hp : !hp;
    e.vs  = (v >= vv + vf && v < vv + vf + vsw) ? vp : !vp;
    e.von = (h < hv) && (v < vv);
    e.ls  = (h == 0);
    e.fs  = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic obs_t rst_val(bit hp, bit vp);
    obs_t e;
    e = '0;
    e.hs = !hp;
    e.vs = !vp;
    return e;
  endfunction

  function automatic obs_t get_a();
    return {ifa.hsync, ifa.vsync, ifa.video_on, ifa.line_start, ifa.frame_start,
            ifa.pixel_x, ifa.pixel_y};
  endfunction

  function automatic obs_t get_b();
    return {ifb.hsync, ifb.vsync, ifb.video_on, ifb.line_start, ifb.frame_start,
            ifb.pixel_x, ifb.pixel_y};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(bit en_a, bit en_b);
    obs_t pre_b;
    pre_b = eb;
    ifa.en = en_a;
    ifb.en = en_b;
    @(posedge clk);
    if (!rst_a_n) begin
      ea = rst_val(1'b1, 1'b1); ah = 0; av = 0;
    end else if (en_a) begin
      ea = predict(ah, av, 800, 56, 120, 600, 37, 6, 1'b1, 1'b1);
      ah = (ah == A_HT - 1) ? 0 : ah + 1;
      if (ah == 0) av = (av == A_VT - 1) ? 0 : av + 1;
    end else begin
      ea.ls = 1'b0; ea.fs = 1'b0;
    end
    if (!rst_b_n) begin
      eb = rst_val(1'b0, 1'b0); bh = 0; bv = 0;
    end else if (en_b) begin
      eb = predict(bh, bv, B_HV, B_HF, B_HS, B_VV, B_VF, B_VS, 1'b0, 1'b0);
      bh = (bh == B_HT - 1) ? 0 : bh + 1;
      if (bh == 0) bv = (bv == B_VT - 1) ? 0 : bv + 1;
    end else begin
      eb.ls = 1'b0; eb.fs = 1'b0;
    end
    @(negedge clk);
    chk("cycle_a", get_a(), ea);
    chk("cycle_b", get_b(), eb);
    if (rst_b_n && en_b) begin
      en_cnt_b++;
      if (pre_b.x == 11'(B_HT - 1)) begin
        chk("wrap_b_x", ifb.pixel_x, 0);
        chk("wrap_b_ls", ifb.line_start, 1);
        chk("wrap_b_fs", ifb.frame_start, pre_b.y == 10'(B_VT - 1));
        chk("wrap_b_y", ifb.pixel_y, (pre_b.y == 10'(B_VT - 1)) ? 0 : pre_b.y + 1);
      end
      if (ifb.vsync == 1'b0) vs_cnt_b++;
      if (ifb.frame_start) begin
        if (last_fs_b >= 0) begin
          chk("fs_period_b", en_cnt_b - last_fs_b, B_HT * B_VT);
          chk("vs_width_b", vs_cnt_b, B_VS * B_HT);
          frames_b++;
        end
        last_fs_b = en_cnt_b;
        vs_cnt_b  = 0;
      end
    end
  endtask

  function automatic bit rnd_en();
    return ($urandom_range(0, 3) != 0);
  endfunction

  initial begin
    bit   von_prev, fall_seen, ls_seen, reached;
    int   hs_cnt;
    ifa.en = 1'b0;
    ifb.en = 1'b0;
    ea = rst_val(1'b1, 1'b1);
    eb = rst_val(1'b0, 1'b0);
    repeat (3) tick(1'b1, 1'b1);
    chk("rst_hsync", ifa.hsync, 0);
    chk("rst_vsync", ifa.vsync, 0);
    chk("rst_video_on", ifa.video_on, 0);
    chk("rst_pixel_x", ifa.pixel_x, 0);
    chk("rst_pixel_y", ifa.pixel_y, 0);
    chk("rst_line_start", ifa.line_start, 0);
    chk("rst_frame_start", ifa.frame_start, 0);
    chk("rst_hsync_b", ifb.hsync, 1);

    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    tick(1'b1, 1'b1);
    chk("first_fs", ifa.frame_start, 1);
    chk("first_ls", ifa.line_start, 1);
    chk("first_von", ifa.video_on, 1);
    chk("first_hsync", ifa.hsync, 0);
    chk("first_vsync", ifa.vsync, 0);
    chk("first_hsync_b", ifb.hsync, 1);
    chk("first_fs_b", ifb.frame_start, 1);

    // one full line on the default instance
    fall_seen = 0; ls_seen = 0; hs_cnt = 0;
    for (int i = 0; i < A_HT; i++) begin
      von_prev = ifa.video_on;
      tick(1'b1, rnd_en());
      if (von_prev && !ifa.video_on) begin
        fall_seen = 1;
        chk("von_fall_x", ifa.pixel_x, 800);
      end
      if (ifa.hsync) hs_cnt++;
      if (ifa.line_start) begin
        ls_seen = 1;
        chk("ls_period", i + 2, A_HT + 1);
      end
    end
    chk("von_fall_seen", fall_seen, 1);
    chk("hsync_width", hs_cnt, 120);
    chk("ls_seen", ls_seen, 1);

    // enable drop at pixel_x=500
    reached = 0;
    for (int i = 0; i < 2 * A_HT && !reached; i++) begin
      tick(1'b1, rnd_en());
      if (ea.x == 11'd500) reached = 1;
    end
    chk("reach_x500", reached, 1);
    chk("pre_hold_x", ifa.pixel_x, 500);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, rnd_en());
      chk("hold_x", ifa.pixel_x, 500);
      chk("hold_ls", ifa.line_start, 0);
      chk("hold_von", ifa.video_on, 1);
    end
    tick(1'b1, rnd_en());
    chk("resume_x", ifa.pixel_x, 501);

    // random enables on both instances; frame-level checks run inside tick
    repeat (1500) tick(1'(($urandom_range(0, 1))), rnd_en());
    chk("frames_b_seen", frames_b >= 3, 1);

    // asynchronous reset on the default instance while hsync is active
    reached = 0;
    for (int i = 0; i < 2 * A_HT && !reached; i++) begin
      tick(1'b1, rnd_en());
      if (ea.x == 11'd900) reached = 1;
    end
    chk("reach_x900", reached, 1);
    chk("pre_rst_hsync", ifa.hsync, 1);
    rst_a_n = 1'b0;
    #1;
    ea = rst_val(1'b1, 1'b1); ah = 0; av = 0;
    chk("async_hsync", ifa.hsync, 0);
    chk("async_pixel_x", ifa.pixel_x, 0);
    chk("async_pixel_y", ifa.pixel_y, 0);
    chk("async_video_on", ifa.video_on, 0);
    tick(1'b1, rnd_en());
    rst_a_n = 1'b1;
    tick(1'b1, rnd_en());
    chk("restart_fs", ifa.frame_start, 1);
    chk("restart_von", ifa.video_on, 1);

    // asynchronous reset on the small instance inside both sync pulses
    reached = 0;
    for (int i = 0; i < 4 * B_HT * B_VT && !reached; i++) begin
      tick(1'b1, 1'b1);
      if (eb.x == 11'd13 && eb.y == 10'd8) reached = 1;
    end
    chk("reach_b_sync", reached, 1);
    chk("pre_rst_hsync_b", ifb.hsync, 0);
    chk("pre_rst_vsync_b", ifb.vsync, 0);
    rst_b_n = 1'b0;
    #1;
    eb = rst_val(1'b0, 1'b0); bh = 0; bv = 0;
    last_fs_b = -1; vs_cnt_b = 0;
    chk("async_hsync_b", ifb.hsync, 1);
    chk("async_vsync_b", ifb.vsync, 1);
    chk("async_pixel_x_b", ifb.pixel_x, 0);
    chk("async_pixel_y_b", ifb.pixel_y, 0);
    tick(1'b1, 1'b1);
    rst_b_n = 1'b1;
    tick(1'b1, 1'b1);
    chk("restart_fs_b", ifb.frame_start, 1);
    chk("restart_ls_b", ifb.line_start, 1);
    frames_b = 0;
    repeat (3 * B_HT * B_VT) tick(rnd_en(), rnd_en());
    chk("frames_b_after_rst", frames_b >= 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
